// File: rtl/imm_gen_pkg.sv
`default_nettype none
// =============================================================================
// imm_gen_pkg : format codes, RV opcodes and XLEN helpers shared by imm_gen_pipe
// Revision 1.0
// =============================================================================
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6
    } fmt_e;

    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;

    localparam logic [2:0] c_F3_SLLI = 3'b001;
    localparam logic [2:0] c_F3_SRXI = 3'b101;

    localparam int c_XLEN_32 = 32;
    localparam int c_XLEN_64 = 64;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == c_XLEN_32) || (xlen == c_XLEN_64);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// =============================================================================
// imm_decode : combinational RV instruction -> extended immediate / format code
// Revision 1.0
// =============================================================================
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o,
    output logic            illegal_o
);

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_shamt;

    assign w_opc   = instr_i[6:0];
    assign w_f3    = instr_i[14:12];
    assign w_imm_i = {{(XLEN-11){instr_i[31]}}, instr_i[30:20]};
    assign w_imm_s = {{(XLEN-11){instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
    assign w_imm_b = {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign w_imm_u = {{(XLEN-31){instr_i[31]}}, instr_i[30:12], 12'b0};
    assign w_imm_j = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // Shift amount excludes funct7/funct6 so SRAI does not leak 0x400 into the immediate.
    if (XLEN == c_XLEN_64) begin : g_shamt64
        assign w_shamt = {{(XLEN-6){1'b0}}, instr_i[25:20]};
    end else begin : g_shamt32
        assign w_shamt = {{(XLEN-5){1'b0}}, instr_i[24:20]};
    end

    always_comb begin
        imm_o     = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        case (w_opc)
            c_OPC_LOAD, c_OPC_JALR, c_OPC_SYSTEM: begin
                fmt_o = FMT_I;
                imm_o = w_imm_i;
            end
            c_OPC_OP_IMM: begin
                if ((w_f3 == c_F3_SLLI) || (w_f3 == c_F3_SRXI)) begin
                    fmt_o = FMT_SH;
                    imm_o = w_shamt;
                end else begin
                    fmt_o = FMT_I;
                    imm_o = w_imm_i;
                end
            end
            c_OPC_STORE: begin
                fmt_o = FMT_S;
                imm_o = w_imm_s;
            end
            c_OPC_BRANCH: begin
                fmt_o = FMT_B;
                imm_o = w_imm_b;
            end
            c_OPC_LUI, c_OPC_AUIPC: begin
                fmt_o = FMT_U;
                imm_o = w_imm_u;
            end
            c_OPC_JAL: begin
                fmt_o = FMT_J;
                imm_o = w_imm_j;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// =============================================================================
// imm_gen_pipe : valid/ready immediate generator with 2-entry skid or 1-entry buffer
// Revision 1.0
// =============================================================================
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam int c_EW = XLEN + 4;

    logic [XLEN-1:0] w_dec_imm;
    fmt_e            w_dec_fmt;
    logic            w_dec_ill;
    logic [c_EW-1:0] w_dec_entry;
    logic            w_push;
    logic            w_pop;

    logic [1:0]      count_q, count_d;
    logic [c_EW-1:0] head_q, head_d;
    logic [c_EW-1:0] tail_q, tail_d;

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i   (instr),
        .imm_o     (w_dec_imm),
        .fmt_o     (w_dec_fmt),
        .illegal_o (w_dec_ill)
    );

    assign w_dec_entry = {w_dec_imm, w_dec_fmt, w_dec_ill};

    // Skid mode keeps in_ready purely registered; single mode trades that for a combinational path.
    if (SKID != 0) begin : g_skid
        assign in_ready = (count_q < 2'd2);
    end else begin : g_single
        assign in_ready = (count_q == 2'd0) || out_ready;
    end

    assign out_valid   = (count_q != 2'd0);
    assign out_imm     = head_q[c_EW-1:4];
    assign out_fmt     = head_q[3:1];
    assign out_illegal = head_q[0];

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({w_push, w_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = w_dec_entry;
                end else begin
                    tail_d = w_dec_entry;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = w_dec_entry;
                end else begin
                    head_d = w_dec_entry;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= {{XLEN{1'b0}}, FMT_NONE, 1'b0};
            tail_q  <= {{XLEN{1'b0}}, FMT_NONE, 1'b0};
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// =============================================================================
// tb_imm_gen_pipe : scoreboard bench for imm_gen_pipe (XLEN=32/SKID=1, XLEN=64/SKID=0)
// Revision 1.0
// =============================================================================
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: XLEN=32, SKID=1
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] instr, out_imm;
    logic [2:0]  out_fmt;

    // Instance B: XLEN=64, SKID=0
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
    logic [31:0] b_instr;
    logic [63:0] b_out_imm;
    logic [2:0]  b_out_fmt;

    imm_gen_pipe #(.XLEN(32), .SKID(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .SKID(0)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .instr(b_instr),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference decode written straight from the ISA immediate layouts.
    function automatic exp_t model(input logic [31:0] w, input int xlen);
        exp_t                e;
        logic signed [11:0]  t12;
        logic signed [12:0]  t13;
        logic signed [20:0]  t21;
        logic signed [31:0]  t32;
        logic signed [63:0]  v;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        v     = '0;
        case (w[6:0])
            7'h03, 7'h67, 7'h73: begin e.fmt = 3'd1; t12 = w[31:20]; v = t12; end
            7'h13: begin
                if (w[14:12] == 3'b001 || w[14:12] == 3'b101) begin
                    e.fmt = 3'd6;
                    if (xlen == 64) v = {58'd0, w[25:20]};
                    else            v = {59'd0, w[24:20]};
                end else begin
                    e.fmt = 3'd1; t12 = w[31:20]; v = t12;
                end
            end
            7'h23: begin e.fmt = 3'd2; t12 = {w[31:25], w[11:7]}; v = t12; end
            7'h63: begin e.fmt = 3'd3; t13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; v = t13; end
            7'h37, 7'h17: begin e.fmt = 3'd4; t32 = {w[31:12], 12'h000}; v = t32; end
            7'h6F: begin e.fmt = 3'd5; t21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; v = t21; end
            default: begin e.fmt = 3'd0; e.ill = 1'b1; v = '0; end
        endcase
        e.imm = (xlen == 32) ? (v & 64'h0000_0000_FFFF_FFFF) : v;
        return e;
    endfunction

    // Scoreboard monitor on instance A: compare on pop, push on accept, check stall stability.
    logic        hold_v = 1'b0;
    logic [31:0] hold_imm;
    logic [2:0]  hold_fmt;
    logic        hold_ill;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (hold_v) begin
                chk("stable_imm", out_imm, hold_imm);
                chk("stable_fmt", out_fmt, hold_fmt);
                chk("stable_ill", out_illegal, hold_ill);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_dup", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_imm", out_imm, e.imm);
                    chk("sb_fmt", out_fmt, e.fmt);
                    chk("sb_ill", out_illegal, e.ill);
                end
            end
            hold_v   = out_valid && !out_ready;
            hold_imm = out_imm;
            hold_fmt = out_fmt;
            hold_ill = out_illegal;
            if (in_valid && in_ready) sb_q.push_back(model(instr, 32));
        end else begin
            hold_v = 1'b0;
            sb_q.delete();
        end
    end

    task automatic expect_out(input string tag, input logic [31:0] imm, input logic [2:0] fmt,
                              input logic ill);
        chk({tag, "_v"}, out_valid, 1);
        chk({tag, "_imm"}, out_imm, imm);
        chk({tag, "_fmt"}, out_fmt, fmt);
        chk({tag, "_ill"}, out_illegal, ill);
    endtask

    task automatic send1(input string tag, input logic [31:0] w, input logic [31:0] imm,
                         input logic [2:0] fmt, input logic ill);
        @(posedge clk); #1;
        in_valid = 1'b1;
        instr    = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        expect_out(tag, imm, fmt, ill);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] sw[4];
    logic [3:0]  exp_rdy;
    logic [31:0] bv[5];
    logic [63:0] be[5];
    logic [2:0]  bf[5];
    logic [4:0]  bi;
    logic [6:0]  op_tab[12];
    exp_t        ex;
    int          acc, k, pv, pr;
    logic        acc_now;
    logic [31:0] r;

    initial begin
        sw      = '{32'h0050_0113, 32'h00C0_00EF, 32'h0020_A023, 32'hFE00_0EE3};
        exp_rdy = 4'b0011;
        bv      = '{32'h8000_02B7, 32'h4030_D093, 32'hFFF0_0093, 32'h02A0_9093, 32'h0000_007F};
        be      = '{64'hFFFF_FFFF_8000_0000, 64'h3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2A, 64'h0};
        bf      = '{3'd4, 3'd6, 3'd1, 3'd6, 3'd0};
        bi      = 5'b10000;
        op_tab  = '{7'h03, 7'h13, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

        // Reset with in_valid high: must be ignored.
        in_valid = 1'b1; instr = 32'h1234_5013; out_ready = 1'b1;
        b_in_valid = 1'b0; b_instr = 32'h0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_fmt", out_fmt, 0);
        chk("rst_ill", out_illegal, 0);
        chk("rst_b_valid", b_out_valid, 0);

        // Back-to-back, accepted on the first edge after release.
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b1; instr = 32'hFFF0_0093;
        @(posedge clk); #1; instr = 32'hFE11_2E23;
        @(negedge clk); expect_out("b2b_i", 32'hFFFF_FFFF, 3'd1, 1'b0);
        @(posedge clk); #1; instr = 32'hFFDF_F06F;
        @(negedge clk); expect_out("b2b_s", 32'hFFFF_FFFC, 3'd2, 1'b0);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); expect_out("b2b_j", 32'hFFFF_FFFC, 3'd5, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); chk("b2b_empty", out_valid, 0);

        send1("lui",   32'h8000_02B7, 32'h8000_0000, 3'd4, 1'b0);
        send1("slli",  32'h01F0_9093, 32'h0000_001F, 3'd6, 1'b0);
        send1("srai",  32'h4030_D093, 32'h0000_0003, 3'd6, 1'b0);
        send1("sh32",  32'h02A0_9093, 32'h0000_000A, 3'd6, 1'b0);
        send1("illeg", 32'h0000_007F, 32'h0000_0000, 3'd0, 1'b1);
        send1("beq",   32'hFE00_0EE3, 32'hFFFF_FFFC, 3'd3, 1'b0);

        // Stall: only two words fit, in_ready drops after the second accept.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; k = 0; acc = 0; instr = sw[0];
        ex = model(sw[0], 32);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stall_rdy", in_ready, exp_rdy[c]);
            acc_now = in_ready;
            if (c >= 1) expect_out("stall_hold", ex.imm[31:0], ex.fmt, ex.ill);
            @(posedge clk); #1;
            if (acc_now) begin
                acc++;
                k++;
                instr = sw[k];
            end
        end
        chk("stall_acc", acc, 2);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); expect_out("drain0", ex.imm[31:0], ex.fmt, ex.ill);
        ex = model(sw[1], 32);
        @(posedge clk); #1;
        @(negedge clk); expect_out("drain1", ex.imm[31:0], ex.fmt, ex.ill);
        @(posedge clk); #1;
        @(negedge clk); chk("drain_empty", out_valid, 0);

        // Fill to two, then asynchronous reset mid-cycle.
        @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b1; instr = sw[2];
        @(posedge clk); #1; instr = sw[3];
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_rdy", in_ready, 0);
        chk("full_valid", out_valid, 1);
        #2; rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_rdy", in_ready, 1);
        chk("arst_imm", out_imm, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); chk("arst_no_partial", out_valid, 0);

        // Random traffic against the scoreboard.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            case ((cyc / 1000) % 4)
                0: begin pv = 90;  pr = 90;  end
                1: begin pv = 50;  pr = 30;  end
                2: begin pv = 20;  pr = 50;  end
                default: begin pv = 100; pr = 60; end
            endcase
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 99) < pv);
            out_ready = ($urandom_range(0, 99) < pr);
            r         = $urandom;
            instr     = {r[31:7], op_tab[$urandom_range(0, 11)]};
        end
        @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb_left", sb_q.size(), 0);
        chk("rand_empty", out_valid, 0);

        // Instance B: one word per cycle with out_ready held high, 64-bit immediates.
        for (int i = 0; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i < 5) begin
                b_in_valid = 1'b1;
                b_instr    = bv[i];
            end else begin
                b_in_valid = 1'b0;
            end
            if (i > 0) begin
                @(negedge clk);
                chk("b_stream_v", b_out_valid, 1);
                chk("b_stream_imm", b_out_imm, be[i-1]);
                chk("b_stream_fmt", b_out_fmt, bf[i-1]);
                chk("b_stream_ill", b_out_illegal, bi[i-1]);
                chk("b_stream_rdy", b_in_ready, 1);
            end
        end
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_instr = 32'hFFDF_F06F; b_out_ready = 1'b0;
        @(posedge clk); #1; b_instr = 32'h8000_02B7;
        @(negedge clk);
        chk("b_stall_rdy", b_in_ready, 0);
        chk("b_stall_imm", b_out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_hold_imm", b_out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("b_hold_fmt", b_out_fmt, 5);
        @(posedge clk); #1; b_out_ready = 1'b1;
        #1; chk("b_comb_rdy", b_in_ready, 1);
        @(posedge clk); #1; b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_next_imm", b_out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("b_next_fmt", b_out_fmt, 4);
        @(posedge clk); #1;
        @(negedge clk); chk("b_empty", b_out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter SKID, default 1, meaning 1 = 2-entry skid buffer (full throughput), 0 = single output register.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning instr is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts instr this cycle.
REQ-007 SHALL have port instr, input, 32, meaning the RV instruction word.
REQ-008 SHALL have port out_valid, output, 1, meaning out_imm, out_fmt and out_illegal are valid.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer accepts the output this cycle.
REQ-010 SHALL have port out_imm, output, XLEN, meaning the extended immediate.
REQ-011 SHALL have port out_fmt, output, 3, meaning the format code: NONE=0, I=1, S=2, B=3, U=4, J=5, SH=6 (shift amount).
REQ-012 SHALL have port out_illegal, output, 1, meaning the opcode is not in the supported set.

Function
REQ-013 SHALL decode by opcode (fmt):
- I: 0000011, 0010011, 1100111, 1110011
- S: 0100011
- B: 1100011
- U: 0110111, 0010111
- J: 1101111
REQ-014 SHALL produce immediates as follows:
- I: sign-extended instr[31:20].
- S: {instr[31:25], instr[11:7]}, sign-extended.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
- U: {instr[31:12], 12'b0}, sign-extended to XLEN.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
REQ-015 SHALL treat opcode 0010011 with funct3 001 or 101 as fmt SH, with out_imm = zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64); funct7/funct6 bits SHALL NOT appear in out_imm.
REQ-016 SHALL output, for any other opcode, fmt NONE, out_imm = 0 and out_illegal = 1; the word SHALL still be accepted and delivered, never dropped.
REQ-017 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-018 SHALL give a word accepted in cycle N on an empty buffer out_valid = 1 in cycle N+1 (latency 1).
REQ-019 SHALL deliver outputs in acceptance order, with no loss and no duplication.
REQ-020 SHALL hold out_imm, out_fmt and out_illegal stable while out_valid && !out_ready.
REQ-021 SHALL, with SKID=1, keep an occupancy count 0..2:
- in_ready = (count < 2), derived from registered state only, with no combinational path from out_ready.
- out_valid = (count > 0).
REQ-022 SHALL, with SKID=1 and count=1, leave count at 1 on simultaneous push and pop, with the new word queued behind the popped one.
REQ-023 SHALL, with SKID=1 and count=2, keep in_ready low; a pop leaves count=1.
REQ-024 SHALL, with SKID=0, use in_ready = !out_valid || out_ready and sustain one word per cycle when out_ready stays high.
REQ-025 SHALL NOT change state when in_valid is low.
REQ-026 SHALL ignore in_valid while rst_n is low.

Reset
REQ-027 SHALL, while rst_n is low, asynchronously force count=0, out_valid=0, out_imm=0, out_fmt=NONE and out_illegal=0.
REQ-028 SHALL discard buffered words on reset mid-operation, with no partial output after release.
REQ-029 SHALL accept input in the first clk edge after rst_n deasserts if in_valid=1.

Structure
REQ-030 SHALL take the fmt codes, opcode constants and legal XLEN values from shared package imm_gen_pkg.
REQ-031 SHALL isolate the combinational decode (instr -> imm, fmt, illegal) in sub-module imm_decode, parametrised by XLEN; the buffer and handshake logic SHALL stay in imm_gen_pipe.

Verification
REQ-032 SHALL cover, XLEN=32, out_ready=1: 0xFFF00093, 0xFE112E23, 0xFFDFF06F back-to-back -> out_imm 0xFFFFFFFF/I, 0xFFFFFFFC/S, 0xFFFFFFFC/J, each on consecutive cycles starting 1 cycle after the first accept.
REQ-033 SHALL cover: 0x800002B7 -> 0x80000000/U at XLEN=32 and 0xFFFFFFFF80000000/U at XLEN=64.
REQ-034 SHALL cover: 0x01F09093 -> 0x1F/SH, and 0x4030D093 -> 0x3/SH (not 0x403).
REQ-035 SHALL cover, SKID=1: out_ready=0 for 4 cycles with in_valid=1 -> exactly 2 words accepted, in_ready low from the cycle after the 2nd accept, outputs stable; then out_ready=1 -> words drain in order.
REQ-036 SHALL cover: opcode 0x7F -> out_illegal=1, out_imm=0, fmt NONE; and rst_n pulsed low with count=2 -> out_valid=0 immediately, count=0.
REQ-037 SHALL check, in a random in_valid/out_ready run of at least 10k cycles, against the scoreboard: order, no loss, no duplication, stability under stall.
